// File: rtl/bs2bin_pkg.sv
// Shared definitions for the pipelined borrow-save to two's complement converter:
// digit codes and the per-digit split into subtrahend/minuend bits.
package bs2bin_pkg;

  localparam logic [1:0] BS_ZERO_A = 2'b00;
  localparam logic [1:0] BS_ZERO_B = 2'b11;
  localparam logic [1:0] BS_POS    = 2'b01;
  localparam logic [1:0] BS_NEG    = 2'b10;

  typedef struct packed {
    logic s;
    logic d;
  } bs_digit_t;

  // Both zero codes normalise to s=d=0; the arithmetic result is the same either way.
  function automatic bs_digit_t bs_split_digit(input logic [1:0] code);
    bs_digit_t r;
    case (code)
      BS_POS:    r = '{s: 1'b0, d: 1'b1};
      BS_NEG:    r = '{s: 1'b1, d: 1'b0};
      BS_ZERO_A: r = '{s: 1'b0, d: 1'b0};
      BS_ZERO_B: r = '{s: 1'b0, d: 1'b0};
      default:   r = '{s: 1'b0, d: 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bs2bin_seg.sv
// Combinational L-digit slice of the conversion carry chain: y = a + ~b + ci.
module bs2bin_seg #(
  parameter int L = 16
) (
  input  logic [L-1:0] a,
  input  logic [L-1:0] b,
  input  logic         ci,
  output logic [L-1:0] y,
  output logic         co
);

  logic [L:0] c;

  always_comb begin
    c    = '0;
    y    = '0;
    c[0] = ci;
    for (int i = 0; i < L; i++) begin
      {c[i+1], y[i]} = {1'b0, a[i]} + {1'b0, ~b[i]} + {1'b0, c[i]};
    end
  end

  assign co = c[L];

endmodule

// File: rtl/bs2bin_pipe.sv
// Pipelined borrow-save to two's complement converter with negate mode, overflow/zero
// flags and an elastic valid/ready handshake; the carry chain is cut into S segments.
module bs2bin_pipe
  import bs2bin_pkg::*;
#(
  parameter int W = 64,
  parameter int S = 4
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_x,
  input  logic           in_neg,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_y,
  output logic           out_ovf,
  output logic           out_zero
);

  localparam int L = W / S;

  if (W < 2 || S < 1 || S > W || (W % S) != 0) begin : g_bad_param
    $error("bs2bin_pipe: need W >= 2, 1 <= S <= W and W a multiple of S");
  end

  logic [W-1:0] a_in, b_in;

  // Negation swaps the operands, so the same adder yields x_s - x_d.
  always_comb begin
    bs_digit_t dg;
    dg   = '0;
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < W; i++) begin
      dg      = bs_split_digit(in_x[2*i +: 2]);
      a_in[i] = in_neg ? dg.s : dg.d;
      b_in[i] = in_neg ? dg.d : dg.s;
    end
  end

  logic [W-1:0] a_p   [S];
  logic [W-1:0] b_p   [S];
  logic [W-1:0] y_p   [S];
  logic         c_p   [S];
  logic         vld_p [S];

  logic [W-1:0] a_stg [S];
  logic [W-1:0] b_stg [S];
  logic [W-1:0] y_stg [S];
  logic         c_stg [S];
  logic         v_stg [S];
  logic [W-1:0] y_nxt [S];
  logic         c_nxt [S];
  logic [S-1:0] rdy;

  // A stage may load when it is empty or everything downstream of it can move.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int k = S - 1; k >= 0; k--) begin
      acc    = acc | ~vld_p[k];
      rdy[k] = acc;
    end
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic [L-1:0] seg_y;

    if (k == 0) begin : g_head
      assign a_stg[k] = a_in;
      assign b_stg[k] = b_in;
      assign y_stg[k] = '0;
      assign c_stg[k] = 1'b1;
      assign v_stg[k] = in_valid;
    end else begin : g_body
      assign a_stg[k] = a_p[k-1];
      assign b_stg[k] = b_p[k-1];
      assign y_stg[k] = y_p[k-1];
      assign c_stg[k] = c_p[k-1];
      assign v_stg[k] = vld_p[k-1];
    end

    bs2bin_seg #(.L(L)) u_seg (
      .a  (a_stg[k][k*L +: L]),
      .b  (b_stg[k][k*L +: L]),
      .ci (c_stg[k]),
      .y  (seg_y),
      .co (c_nxt[k])
    );

    always_comb begin
      y_nxt[k]            = y_stg[k];
      y_nxt[k][k*L +: L]  = seg_y;
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        vld_p[k] <= 1'b0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        y_p[k]   <= '0;
        c_p[k]   <= 1'b0;
      end else begin
        if (rdy[k]) vld_p[k] <= v_stg[k];
        if (rdy[k] && v_stg[k]) begin
          a_p[k] <= a_stg[k];
          b_p[k] <= b_stg[k];
          y_p[k] <= y_nxt[k];
          c_p[k] <= c_nxt[k];
        end
      end
    end
  end

  logic ovf_p, zero_p;

  // Exact sign is the inverted final carry; overflow when it disagrees with y[W-1].
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ovf_p  <= 1'b0;
      zero_p <= 1'b0;
    end else if (rdy[S-1] && v_stg[S-1]) begin
      ovf_p  <= ~c_nxt[S-1] ^ y_nxt[S-1][W-1];
      zero_p <= (y_nxt[S-1] == '0);
    end
  end

  assign out_valid = vld_p[S-1];
  assign out_y     = y_p[S-1];
  assign out_ovf   = ovf_p;
  assign out_zero  = zero_p;

endmodule

// File: tb/tb_bs2bin_pipe.sv
// Scoreboard bench for bs2bin_pipe: W=8/S=2 directed, streaming, stall and reset
// scenarios, plus W=64 instances at S=1, 4 and 64 fed a shared random stream.
module tb_bs2bin_pipe;

  localparam int W = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           arst_n, in_valid, in_neg, in_ready, out_valid, out_ready, out_ovf, out_zero;
  logic [2*W-1:0] in_x;
  logic [W-1:0]   out_y;

  bs2bin_pipe #(.W(W), .S(S)) dut (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_neg(in_neg), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_ovf(out_ovf), .out_zero(out_zero)
  );

  logic [127:0] x64;
  logic         v64, n64;
  logic [63:0]  y_a, y_b, y_c;
  logic         r_a, r_b, r_c, ov_a, ov_b, ov_c, o_a, o_b, o_c, z_a, z_b, z_c;

  bs2bin_pipe #(.W(64), .S(1)) u_s1 (
    .clk(clk), .arst_n(arst_n), .in_valid(v64), .in_ready(r_a), .in_x(x64), .in_neg(n64),
    .out_valid(ov_a), .out_ready(1'b1), .out_y(y_a), .out_ovf(o_a), .out_zero(z_a)
  );
  bs2bin_pipe #(.W(64), .S(4)) u_s4 (
    .clk(clk), .arst_n(arst_n), .in_valid(v64), .in_ready(r_b), .in_x(x64), .in_neg(n64),
    .out_valid(ov_b), .out_ready(1'b1), .out_y(y_b), .out_ovf(o_b), .out_zero(z_b)
  );
  bs2bin_pipe #(.W(64), .S(64)) u_s64 (
    .clk(clk), .arst_n(arst_n), .in_valid(v64), .in_ready(r_c), .in_x(x64), .in_neg(n64),
    .out_valid(ov_c), .out_ready(1'b1), .out_y(y_c), .out_ovf(o_c), .out_zero(z_c)
  );

  typedef struct {
    logic [63:0] y;
    logic        ovf;
    logic        zero;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  exp_t q[$];
  exp_t exp64 [64];
  int   n_iss64 = 0;
  int   rp [3];
  int   n_cmp = 0, n_err = 0, cyc = 0, held = 0;
  bit   saw_stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) held <= 0;
    else held <= held + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Arithmetic golden model: sum of signed digit weights, then range test.
  function automatic exp_t model(input int w, input logic [127:0] x, input logic neg);
    logic signed [69:0] r, p, lim;
    logic [63:0] mask;
    exp_t e;
    r = '0;
    p = 70'sd1;
    for (int i = 0; i < w; i++) begin
      if (x[2*i +: 2] == 2'b01) r = r + p;
      else if (x[2*i +: 2] == 2'b10) r = r - p;
      p = p <<< 1;
    end
    if (neg) r = -r;
    lim       = 70'sd1 <<< (w - 1);
    mask      = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    e.ovf     = (r >= lim) || (r < -lim);
    e.y       = r[63:0] & mask;
    e.zero    = (e.y == 64'd0);
    e.cyc     = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (arst_n === 1'b1) begin
      check("in_ready", {63'd0, in_ready}, {63'd0, (held < S) || out_ready});
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_out: got out_valid=1 y=%h, expected no output", out_y);
        end else begin
          check("out_y", {56'd0, out_y}, q[0].y);
          check("out_ovf", {63'd0, out_ovf}, {63'd0, q[0].ovf});
          check("out_zero", {63'd0, out_zero}, {63'd0, q[0].zero});
          if (out_ready) begin
            if (q[0].chk_lat) check("latency", 64'(cyc - q[0].cyc), 64'(S));
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic mon64(input int j, input logic [63:0] y, input logic o, input logic z, input int s);
    exp_t e;
    if (rp[j] >= n_iss64) begin
      n_cmp++; n_err++;
      $display("FAIL spurious_out64_s%0d: got y=%h, expected no output", s, y);
    end else begin
      e = exp64[rp[j]];
      check($sformatf("y64_s%0d", s), y, e.y);
      check($sformatf("ovf64_s%0d", s), {63'd0, o}, {63'd0, e.ovf});
      check($sformatf("zero64_s%0d", s), {63'd0, z}, {63'd0, e.zero});
      check($sformatf("lat64_s%0d", s), 64'(cyc - e.cyc), 64'(s));
      rp[j]++;
    end
  endtask

  always @(negedge clk) begin
    if (arst_n === 1'b1) begin
      if (ov_a) mon64(0, y_a, o_a, z_a, 1);
      if (ov_b) mon64(1, y_b, o_b, z_b, 4);
      if (ov_c) mon64(2, y_c, o_c, z_c, 64);
    end
  end

  task automatic send(input logic [15:0] x, input logic neg, input logic [7:0] ey,
                      input logic eo, input logic ez, input bit lat);
    int t = 0;
    in_x = x; in_neg = neg; in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
        break;
      end
    end
    if (t <= 50) q.push_back('{y: {56'd0, ey}, ovf: eo, zero: ez, cyc: cyc, chk_lat: lat});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin @(posedge clk); t++; end
    #1;
    check("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    arst_n = 1'b1; in_valid = 1'b0; in_x = '0; in_neg = 1'b0; out_ready = 1'b1;
    x64 = '0; v64 = 1'b0; n64 = 1'b0;
    rp[0] = 0; rp[1] = 0; rp[2] = 0;
    #1 arst_n = 1'b0;
    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_y", {56'd0, out_y}, 64'd0);
    check("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
    check("rst_out_zero", {63'd0, out_zero}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;

    // Directed vectors, hand-computed (W=8).
    send(16'h001B, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    send(16'h5555, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    send(16'h5555, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
    send(16'h8000, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
    send(16'hFFFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    send(16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    send(16'h0002, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    send(16'h4000, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
    send(16'h4000, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1);
    send(16'h0001, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    send(16'h6AAA, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    in_x = 16'h5555;
    idle(4);
    drain();

    // W=64 regression across S=1, 4, 64.
    for (int i = 0; i < 24; i++) begin
      x64 = (i == 0) ? {64{2'b01}} : {$urandom, $urandom, $urandom, $urandom};
      n64 = (i == 1) ? 1'b1 : 1'($urandom);
      if (i == 1) x64 = {64{2'b01}};
      v64 = 1'b1;
      @(negedge clk);
      check("rdy64", {61'd0, r_a, r_b, r_c}, 64'd7);
      e = model(64, x64, n64);
      e.cyc = cyc;
      exp64[n_iss64] = e;
      n_iss64++;
      @(posedge clk); #1;
    end
    v64 = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) check($sformatf("count64_%0d", j), 64'(rp[j]), 64'(n_iss64));

    // Streaming 10 random words with a 4-cycle output stall.
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [15:0] xs;
          logic ns;
          exp_t es;
          xs = 16'($urandom);
          ns = 1'($urandom);
          es = model(W, {112'd0, xs}, ns);
          send(xs, ns, es.y[7:0], es.ovf, es.zero, 1'b0);
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_seen", {63'd0, saw_stall}, 64'd1);

    // Reset with two words held in the pipe.
    out_ready = 1'b0;
    send(16'h5555, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    send(16'h001B, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    arst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_out_y", {56'd0, out_y}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    q.delete();
    @(posedge clk); #2;
    arst_n = 1'b1;
    out_ready = 1'b1;
    idle(4);
    send(16'h001B, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
